// File: rtl/alu_wb_if.sv
// alu_wb_if: ALU result beat, VRF write port and stall bundle for alu_wb_buffer
interface alu_wb_if #(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4,
    parameter int ADDR_WIDTH      = 9
);
    logic [PARALLEL_IF_NUM*OP_WIDTH-1:0]     alu_res_i;
    logic [PARALLEL_IF_NUM-1:0]              alu_vld_i;
    logic [PARALLEL_IF_NUM-1:0]              alu_mask_vector_i;
    logic [1:0]                              sew_i;
    logic [ADDR_WIDTH-1:0]                   wb_addr_i;
    logic                                    wb_mask_op_i;
    logic                                    wb_last_i;
    logic                                    alu_stall_o;
    logic [PARALLEL_IF_NUM*OP_WIDTH-1:0]     vrf_wdata_o;
    logic [PARALLEL_IF_NUM*(OP_WIDTH/8)-1:0] vrf_wbe_o;
    logic [ADDR_WIDTH-1:0]                   vrf_waddr_o;
    logic                                    vrf_wvld_o;
    logic                                    vrf_wrdy_i;
    modport master (
        output alu_res_i, alu_vld_i, alu_mask_vector_i, sew_i, wb_addr_i, wb_mask_op_i, wb_last_i, vrf_wrdy_i,
        input  alu_stall_o, vrf_wdata_o, vrf_wbe_o, vrf_waddr_o, vrf_wvld_o
    );
    modport slave (
        input  alu_res_i, alu_vld_i, alu_mask_vector_i, sew_i, wb_addr_i, wb_mask_op_i, wb_last_i, vrf_wrdy_i,
        output alu_stall_o, vrf_wdata_o, vrf_wbe_o, vrf_waddr_o, vrf_wvld_o
    );
endinterface

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: collects ALU lane results into byte-enabled VRF writes, packs compare bits into mask words
module alu_wb_buffer #(
    parameter int OP_WIDTH        = 32,
    parameter int PARALLEL_IF_NUM = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int ADDR_WIDTH      = 9
) (
    input logic     clk,
    input logic     rst,
    alu_wb_if.slave bus
);
    localparam int P     = PARALLEL_IF_NUM;
    localparam int BPL   = OP_WIDTH / 8;
    localparam int DW    = P * OP_WIDTH;
    localparam int BW    = P * BPL;
    localparam int BEATS = OP_WIDTH / P;
    localparam int PW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int AW    = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(BEATS - 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

    logic [DW-1:0]         mem_data [FIFO_DEPTH];
    logic [BW-1:0]         mem_wbe  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [PW-1:0]         ptr;
    logic [OP_WIDTH-1:0]   mask_acc, mask_next;
    logic [P-1:0]          bits;
    logic [BPL-1:0]        sew_be;
    logic [DW-1:0]         push_data;
    logic [BW-1:0]         push_wbe;
    logic                  accept, finalize, push, pop;

    assign bus.vrf_wvld_o  = count != '0;
    assign bus.alu_stall_o = count == FULL;
    assign bus.vrf_wdata_o = bus.vrf_wvld_o ? mem_data[rd_ptr] : '0;
    assign bus.vrf_wbe_o   = bus.vrf_wvld_o ? mem_wbe[rd_ptr]  : '0;
    assign bus.vrf_waddr_o = bus.vrf_wvld_o ? mem_addr[rd_ptr] : '0;
    assign pop             = bus.vrf_wvld_o && bus.vrf_wrdy_i;

    always_comb begin
        accept    = (|bus.alu_vld_i) && !bus.alu_stall_o;
        bits      = bus.alu_mask_vector_i & bus.alu_vld_i;
        mask_next = mask_acc | (OP_WIDTH'(bits) << (ptr * P));
        finalize  = accept && bus.wb_mask_op_i && (ptr == PTR_MAX || bus.wb_last_i);
        push      = accept && (!bus.wb_mask_op_i || finalize);
        sew_be    = bus.sew_i == 2'd0 ? BPL'(1) : bus.sew_i == 2'd1 ? BPL'(3) : BPL'(15);
        push_wbe  = '0;
        for (int i = 0; i < P; i++)
            push_wbe[i*BPL +: BPL] = bus.alu_vld_i[i] ? sew_be : '0;
        push_data = bus.wb_mask_op_i ? DW'(mask_next) : bus.alu_res_i;
        push_wbe  = bus.wb_mask_op_i ? BW'({BPL{1'b1}}) : push_wbe;
    end

    // storage carries no reset; heads are gated by vrf_wvld_o so stale contents never show
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_wbe[wr_ptr]  <= push_wbe;
            mem_addr[wr_ptr] <= bus.wb_addr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ptr      <= '0;
            mask_acc <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (accept && bus.wb_mask_op_i) begin
                mask_acc <= finalize ? '0 : mask_next;
                ptr      <= finalize ? '0 : ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer: directed checks of alu_wb_buffer write entries, mask packing, backpressure and reset
module tb_alu_wb_buffer;
    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;

    alu_wb_if #(.OP_WIDTH(32), .PARALLEL_IF_NUM(4), .ADDR_WIDTH(9)) bus ();

    alu_wb_buffer #(.OP_WIDTH(32), .PARALLEL_IF_NUM(4), .FIFO_DEPTH(4), .ADDR_WIDTH(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] vld, input logic [3:0] mvec, input logic mop, input logic last,
                        input logic [8:0] addr, input logic [127:0] res, input logic [1:0] sew);
        bus.alu_vld_i         = vld;
        bus.alu_mask_vector_i = mvec;
        bus.wb_mask_op_i      = mop;
        bus.wb_last_i         = last;
        bus.wb_addr_i         = addr;
        bus.alu_res_i         = res;
        bus.sew_i             = sew;
        tick();
        bus.alu_vld_i = '0;
        bus.wb_last_i = 1'b0;
    endtask

    initial begin
        bus.alu_res_i = '0; bus.alu_vld_i = '0; bus.alu_mask_vector_i = '0; bus.sew_i = '0;
        bus.wb_addr_i = '0; bus.wb_mask_op_i = 0; bus.wb_last_i = 0; bus.vrf_wrdy_i = 0;
        tick(); tick();
        chk("rst_wvld", 128'(bus.vrf_wvld_o), 128'd0);
        chk("rst_stall", 128'(bus.alu_stall_o), 128'd0);
        chk("rst_wdata", bus.vrf_wdata_o, 128'd0);
        chk("rst_wbe", 128'(bus.vrf_wbe_o), 128'd0);
        chk("rst_waddr", 128'(bus.vrf_waddr_o), 128'd0);
        rst = 0;
        tick();

        // single normal beat, sew=16b, lanes 0 and 2
        bus.vrf_wrdy_i = 1;
        beat(4'b0101, 4'b0000, 0, 0, 9'h12, {32'd4, 32'd3, 32'd2, 32'd1}, 2'd1);
        chk("n_wvld", 128'(bus.vrf_wvld_o), 128'd1);
        chk("n_addr", 128'(bus.vrf_waddr_o), 128'h12);
        chk("n_data", bus.vrf_wdata_o, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("n_wbe", 128'(bus.vrf_wbe_o), 128'h0303);
        tick();
        chk("n_drain", 128'(bus.vrf_wvld_o), 128'd0);

        // full mask word: 8 beats of 1010
        for (int k = 0; k < 7; k++) beat(4'hF, 4'b1010, 1, 0, 9'h30 + 9'(k), '0, 2'd2);
        chk("m_nowrite", 128'(bus.vrf_wvld_o), 128'd0);
        beat(4'hF, 4'b1010, 1, 0, 9'h40, '0, 2'd2);
        chk("m_wvld", 128'(bus.vrf_wvld_o), 128'd1);
        chk("m_data", bus.vrf_wdata_o, 128'hAAAAAAAA);
        chk("m_addr", 128'(bus.vrf_waddr_o), 128'h40);
        chk("m_wbe", 128'(bus.vrf_wbe_o), 128'h000F);
        tick();
        chk("m_single", 128'(bus.vrf_wvld_o), 128'd0);

        // short mask word finalized by wb_last_i, then a new word starts at bit 0
        beat(4'hF, 4'hF, 1, 0, 9'h50, '0, 2'd2);
        beat(4'hF, 4'hF, 1, 0, 9'h50, '0, 2'd2);
        chk("s_nowrite", 128'(bus.vrf_wvld_o), 128'd0);
        beat(4'hF, 4'hF, 1, 1, 9'h50, '0, 2'd2);
        chk("s_data", bus.vrf_wdata_o, 128'h00000FFF);
        chk("s_addr", 128'(bus.vrf_waddr_o), 128'h50);
        beat(4'hF, 4'b0001, 1, 1, 9'h51, '0, 2'd2);
        chk("s_restart", bus.vrf_wdata_o, 128'h1);
        tick();

        // backpressure: 5 beats into a 4-deep FIFO
        bus.vrf_wrdy_i = 0;
        bus.wb_mask_op_i = 0;
        for (int k = 0; k < 4; k++) begin
            chk("b_nostall", 128'(bus.alu_stall_o), 128'd0);
            beat(4'hF, 4'h0, 0, 0, 9'h60 + 9'(k), {4{32'hA0 + 32'(k)}}, 2'd2);
        end
        chk("b_stall", 128'(bus.alu_stall_o), 128'd1);
        beat(4'hF, 4'h0, 0, 0, 9'h64, {4{32'hA4}}, 2'd2);
        chk("b_stall_hold", 128'(bus.alu_stall_o), 128'd1);
        chk("b_head0", 128'(bus.vrf_waddr_o), 128'h60);
        chk("b_data0", bus.vrf_wdata_o, {4{32'hA0}});
        chk("b_wbe0", 128'(bus.vrf_wbe_o), 128'hFFFF);
        bus.vrf_wrdy_i = 1;
        tick();
        chk("b_stall_fall", 128'(bus.alu_stall_o), 128'd0);
        chk("b_head1", 128'(bus.vrf_waddr_o), 128'h61);
        tick();
        chk("b_head2", 128'(bus.vrf_waddr_o), 128'h62);
        tick();
        chk("b_head3", 128'(bus.vrf_waddr_o), 128'h63);
        chk("b_data3", bus.vrf_wdata_o, {4{32'hA3}});
        tick();
        chk("b_no5th", 128'(bus.vrf_wvld_o), 128'd0);

        // three queued, then push and pop together
        bus.vrf_wrdy_i = 0;
        for (int k = 0; k < 3; k++) beat(4'hF, 4'h0, 0, 0, 9'h70 + 9'(k), '0, 2'd0);
        chk("pp_nostall3", 128'(bus.alu_stall_o), 128'd0);
        bus.vrf_wrdy_i = 1;
        beat(4'hF, 4'h0, 0, 0, 9'h73, '0, 2'd0);
        chk("pp_nostall", 128'(bus.alu_stall_o), 128'd0);
        chk("pp_head", 128'(bus.vrf_waddr_o), 128'h71);
        bus.vrf_wrdy_i = 0;
        beat(4'h1, 4'h0, 0, 0, 9'h74, '0, 2'd0);
        chk("pp_full", 128'(bus.alu_stall_o), 128'd1);
        chk("pp_wbe", 128'(bus.vrf_wbe_o), 128'h1111);
        bus.vrf_wrdy_i = 1;
        for (int k = 1; k < 5; k++) begin
            chk("pp_order", 128'(bus.vrf_waddr_o), 128'h70 + 128'(k));
            tick();
        end
        chk("pp_empty", 128'(bus.vrf_wvld_o), 128'd0);

        // reset with two entries queued and a mask word at ptr=5
        bus.vrf_wrdy_i = 0;
        beat(4'hF, 4'h0, 0, 0, 9'h80, '0, 2'd2);
        beat(4'hF, 4'h0, 0, 0, 9'h81, '0, 2'd2);
        for (int k = 0; k < 5; k++) beat(4'hF, 4'hF, 1, 0, 9'h85, '0, 2'd2);
        chk("r_pre", 128'(bus.vrf_waddr_o), 128'h80);
        #2 rst = 1;
        #1;
        chk("r_wvld", 128'(bus.vrf_wvld_o), 128'd0);
        chk("r_waddr", 128'(bus.vrf_waddr_o), 128'd0);
        #1 rst = 0;
        bus.vrf_wrdy_i = 1;
        tick();
        chk("r_nostale", 128'(bus.vrf_wvld_o), 128'd0);
        beat(4'hF, 4'b0001, 1, 1, 9'h90, '0, 2'd2);
        chk("r_fresh", bus.vrf_wdata_o, 128'h1);
        chk("r_addr", 128'(bus.vrf_waddr_o), 128'h90);
        tick();
        chk("r_empty", 128'(bus.vrf_wvld_o), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
